csi_2_phy_tx_data_lane: RTL and testbench
=========================================

// Module: csi_2_phy_tx_data_lane
// PURPOSE
//  CSI-2 D-PHY data-lane transmitter: far end of the lane that CSI_2_PHY_Rx_Data_Lane receives.
//  Takes PPI-style bytes from the packet layer and drives the lane on Dp/Dn:
//  LP-11 stop -> LP-01 -> LP-00 -> HS-zero -> sync 0xB8 -> HS data -> HS-trail -> LP-11.
//  Serial rate is 1 bit per TxDDRClkHS rising edge, LSB first; Dp/Dn is a logic-level lane model.
// PARAMETERS
//  T_LPX         2      cycles of LP-01
//  T_HS_PREPARE  2      cycles of LP-00
//  T_HS_ZERO     6      cycles of HS-0 before sync
//  T_HS_TRAIL    4      cycles of inverted last bit after final byte
//  T_HS_EXIT     4      cycles of LP-11 before Stopstate reasserts
//  SYNC_BYTE     8'hB8  HS sync leader
//  All T_* must be in the range 1..255; counters are 8 bits wide.
// PORTS
//  TxDDRClkHS   in   1  bit clock; the only clock
//  Shutdown     in   1  asynchronous, active-high reset
//  TxRequestHS  in   1  upstream requests HS burst; held high while bytes remain
//  TxDataHS     in   8  byte to send; sampled on the edge where TxReadyHS=1
//  TxReadyHS    out  1  byte-accept strobe
//  Stopstate    out  1  lane in LP-11 stop state
//  ActiveHS     out  1  lane driven differentially (HS_ZERO..HS_TRAIL)
//  Dp           out  1  lane positive
//  Dn           out  1  lane negative
//  TxByteClkHS  out  1  only with CSI_TX_BYTECLK_EN
// BEHAVIOUR
//  Reset (Shutdown=1, async): state=STOP; Dp=1, Dn=1; Stopstate=1; ActiveHS=0; TxReadyHS=0;
//    bit counter=0. This holds mid-burst: the lane returns to LP-11 immediately, with no trail.
//  Dp/Dn, Stopstate and ActiveHS are decoded from registered state and shift register only (glitch-free).
//  States and levels:
//    STOP LP-11 | LP01 Dp=0/Dn=1 | LP00 0/0 | HS_ZERO 0/1 | HS_SYNC, HS_DATA Dp=bit, Dn=~bit
//    HS_TRAIL Dp=~last, Dn=last | HS_EXIT LP-11
//  Transitions:
//    STOP->LP01 on the edge sampling TxRequestHS=1.
//    LP01, LP00, HS_ZERO, HS_TRAIL and HS_EXIT each last exactly their T_* cycles, then advance.
//    HS_ZERO->HS_SYNC loads SYNC_BYTE.
//  Byte handshake: in HS_SYNC/HS_DATA at bit_cnt==7:
//    TxReadyHS = TxRequestHS (combinational from that register state and the input).
//    If 1: TxDataHS is loaded at that edge, the state is HS_DATA, and its bit0 drives the next cycle.
//    If 0: state goes to HS_TRAIL. The sync byte is always sent, even if the request drops early.
//  TxRequestHS is ignored in every other state. After HS_EXIT the block returns to STOP, with
//    Stopstate=1 for at least 1 cycle before a new request is accepted.
//  Back-to-back bytes: no gaps. One byte every 8 cycles and exactly 1 TxReadyHS pulse per byte.
//  "last" = final data bit sent (sync bit7 if there were zero data bytes).
//  Latency: the request edge leaves STOP; the first sync bit appears T_LPX+T_HS_PREPARE+T_HS_ZERO
//    cycles later.
// CONFIGURATION
//  CSI_TX_BYTECLK_EN defined: adds output TxByteClkHS = (bit_cnt<4), an 8-cycle period.
//    It free-runs in all states; bit_cnt keeps counting outside HS and resets to 0 on Shutdown.
//    Entry to HS_SYNC realigns bit_cnt to 0.
//  Undefined: the port is absent, and bit_cnt is held at 0 outside HS_SYNC/HS_DATA.
// STRUCTURE
//  Package csi2_tx_pkg:
//    state encoding (STOP, LP01, LP00, HS_ZERO, HS_SYNC, HS_DATA, HS_TRAIL, HS_EXIT)
//    CSI2_SYNC_BYTE=8'hB8
//    LP level constants LP11/LP01/LP00
//  Sub-module csi2_tx_serializer: 8-bit LSB-first shift register + 3-bit bit counter, with
//    load/shift controls and last-bit flag. The FSM and timing counter stay in the top module.
// TESTING (defaults)
//  1) Reset then idle, TxRequestHS=0 -> Dp=Dn=1, Stopstate=1, TxReadyHS never asserts.
//  2) Request 1 byte 8'h5A:
//     - Dp/Dn = 01 x2, 00 x2, 01 x6
//     - then bits 0,0,0,1,1,1,0,1 (sync), then 0,1,0,1,1,0,1,0
//     - then trail Dp=1/Dn=0 x4, LP-11 x4, Stopstate=1
//  3) Request held for 3 bytes 11,22,33 -> 24 contiguous data bits, exactly 3 TxReadyHS pulses
//     8 cycles apart.
//  4) Request dropped during LP00 -> sync sent, 0 TxReadyHS pulses, trail Dp=0/Dn=1
//     (inverse of sync bit7=1).
//  5) Shutdown pulsed mid HS_DATA -> same cycle Dp=Dn=1, Stopstate=1; next request restarts at LP01.
//  6) With CSI_TX_BYTECLK_EN: TxByteClkHS rises on each bit0 of sync/data.
//     Without it: the build has no such port.

Source files
------------

// File: rtl/csi2_tx_pkg.sv
// rtl/csi2_tx_pkg.sv - shared state encoding and lane level constants for the CSI-2 D-PHY data-lane transmitter
package csi2_tx_pkg;

  typedef enum logic [2:0] {
    STOP,
    LP01,
    LP00,
    HS_ZERO,
    HS_SYNC,
    HS_DATA,
    HS_TRAIL,
    HS_EXIT
  } tx_state_e;

  localparam logic [7:0] CSI2_SYNC_BYTE = 8'hB8;

  // Lane levels packed as {Dp, Dn}
  localparam logic [1:0] LVL_LP11 = 2'b11;
  localparam logic [1:0] LVL_LP01 = 2'b01;
  localparam logic [1:0] LVL_LP00 = 2'b00;
  localparam logic [1:0] LVL_HS0  = 2'b01;

endpackage

// File: rtl/csi2_tx_serializer.sv
// rtl/csi2_tx_serializer.sv - LSB-first byte shifter with 3-bit bit counter and captured final bit
module csi2_tx_serializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       hs,
  input  logic       free_run,
  input  logic [7:0] data,
  output logic       tx_bit,
  output logic [2:0] bit_cnt,
  output logic       last_bit
);

  logic [7:0] shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      last_bit <= 1'b0;
    end else begin
      // The bit on the wire at bit_cnt==7 is the final bit of the byte; keep it for the trail.
      if (hs && bit_cnt == 3'd7) last_bit <= shreg[0];
      if (load) begin
        shreg   <= data;
        bit_cnt <= 3'd0;
      end else begin
        if (hs) shreg <= {1'b0, shreg[7:1]};
        bit_cnt <= (hs || free_run) ? bit_cnt + 3'd1 : 3'd0;
      end
    end
  end

  assign tx_bit = shreg[0];

endmodule

// File: rtl/csi_2_phy_tx_data_lane.sv
// rtl/csi_2_phy_tx_data_lane.sv - CSI-2 D-PHY data-lane transmitter: LP-11 -> LP-01 -> LP-00 -> HS burst -> trail -> LP-11
// Optional CSI_TX_BYTECLK_EN adds the free-running TxByteClkHS output.
module csi_2_phy_tx_data_lane
  import csi2_tx_pkg::*;
#(
  parameter logic [7:0] T_LPX        = 8'd2,
  parameter logic [7:0] T_HS_PREPARE = 8'd2,
  parameter logic [7:0] T_HS_ZERO    = 8'd6,
  parameter logic [7:0] T_HS_TRAIL   = 8'd4,
  parameter logic [7:0] T_HS_EXIT    = 8'd4,
  parameter logic [7:0] SYNC_BYTE    = CSI2_SYNC_BYTE
) (
  input  logic       TxDDRClkHS,
  input  logic       Shutdown,
  input  logic       TxRequestHS,
  input  logic [7:0] TxDataHS,
  output logic       TxReadyHS,
  output logic       Stopstate,
  output logic       ActiveHS,
  output logic       Dp,
  output logic       Dn
`ifdef CSI_TX_BYTECLK_EN
  ,
  output logic       TxByteClkHS
`endif
);

  tx_state_e  state_q, state_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic [7:0] tlen;
  logic       tdone;
  logic       in_hs;
  logic       byte_end;
  logic       load;
  logic [7:0] load_data;
  logic       free_run;
  logic       tx_bit;
  logic       last_bit;
  logic [2:0] bit_cnt;
  logic [1:0] lvl;

`ifdef CSI_TX_BYTECLK_EN
  assign free_run    = 1'b1;
  assign TxByteClkHS = (bit_cnt < 3'd4);
`else
  assign free_run = 1'b0;
`endif

  assign in_hs     = (state_q == HS_SYNC) || (state_q == HS_DATA);
  assign byte_end  = (bit_cnt == 3'd7);
  assign TxReadyHS = in_hs && byte_end && TxRequestHS;

  always_comb begin
    tlen = 8'd1;
    case (state_q)
      LP01:     tlen = T_LPX;
      LP00:     tlen = T_HS_PREPARE;
      HS_ZERO:  tlen = T_HS_ZERO;
      HS_TRAIL: tlen = T_HS_TRAIL;
      HS_EXIT:  tlen = T_HS_EXIT;
      default:  tlen = 8'd1;
    endcase
  end

  assign tdone = (tcnt_q == tlen - 8'd1);

  always_ff @(posedge TxDDRClkHS or posedge Shutdown) begin
    if (Shutdown) begin
      state_q <= STOP;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q + 8'd1;
    load      = 1'b0;
    load_data = SYNC_BYTE;
    case (state_q)
      STOP: begin
        tcnt_d = '0;
        if (TxRequestHS) state_d = LP01;
      end
      LP01: if (tdone) begin state_d = LP00; tcnt_d = '0; end
      LP00: if (tdone) begin state_d = HS_ZERO; tcnt_d = '0; end
      HS_ZERO: begin
        if (tdone) begin
          state_d = HS_SYNC;
          tcnt_d  = '0;
          load    = 1'b1;
        end
      end
      HS_SYNC, HS_DATA: begin
        tcnt_d = '0;
        if (byte_end) begin
          if (TxRequestHS) begin
            state_d   = HS_DATA;
            load      = 1'b1;
            load_data = TxDataHS;
          end else begin
            state_d = HS_TRAIL;
          end
        end
      end
      HS_TRAIL: if (tdone) begin state_d = HS_EXIT; tcnt_d = '0; end
      HS_EXIT:  if (tdone) begin state_d = STOP; tcnt_d = '0; end
      default: begin
        state_d = STOP;
        tcnt_d  = '0;
      end
    endcase
  end

  csi2_tx_serializer u_ser (
    .clk      (TxDDRClkHS),
    .rst      (Shutdown),
    .load     (load),
    .hs       (in_hs),
    .free_run (free_run),
    .data     (load_data),
    .tx_bit   (tx_bit),
    .bit_cnt  (bit_cnt),
    .last_bit (last_bit)
  );

  // Lane levels come only from registered state so Dp/Dn never glitch on input changes.
  always_comb begin
    lvl = LVL_LP11;
    case (state_q)
      LP01:             lvl = LVL_LP01;
      LP00:             lvl = LVL_LP00;
      HS_ZERO:          lvl = LVL_HS0;
      HS_SYNC, HS_DATA: lvl = {tx_bit, ~tx_bit};
      HS_TRAIL:         lvl = {~last_bit, last_bit};
      default:          lvl = LVL_LP11;
    endcase
  end

  assign Dp        = lvl[1];
  assign Dn        = lvl[0];
  assign Stopstate = (state_q == STOP);
  assign ActiveHS  = (state_q == HS_ZERO) || in_hs || (state_q == HS_TRAIL);

endmodule

// File: tb/tb_csi_2_phy_tx_data_lane.sv
// tb/tb_csi_2_phy_tx_data_lane.sv - table-driven self-checking bench for csi_2_phy_tx_data_lane
module tb_csi_2_phy_tx_data_lane;

  logic       clk = 1'b0;
  logic       shutdown;
  logic       req;
  logic [7:0] data;
  logic       rdy, stop, act, dp, dn;
`ifdef CSI_TX_BYTECLK_EN
  logic       bclk;
`endif

  always #5 clk = ~clk;

  csi_2_phy_tx_data_lane dut (
    .TxDDRClkHS  (clk),
    .Shutdown    (shutdown),
    .TxRequestHS (req),
    .TxDataHS    (data),
    .TxReadyHS   (rdy),
    .Stopstate   (stop),
    .ActiveHS    (act),
    .Dp          (dp),
    .Dn          (dn)
`ifdef CSI_TX_BYTECLK_EN
    ,
    .TxByteClkHS (bclk)
`endif
  );

  typedef struct {
    logic       req;
    logic [7:0] data;
    logic       dp;
    logic       dn;
    logic       stop;
    logic       act;
    logic       rdy;
    int         bit_idx;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;
  int   rdy_seen = 0;

  task automatic chk(input string name, input int step, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s step=%0d got=%b want=%b", name, step, got, want);
    end
  endtask

  task automatic add(input logic r, input logic [7:0] d, input logic [1:0] lvl,
                     input logic s, input logic a, input logic y, input int bi);
    vec_t v;
    v.req = r; v.data = d; v.dp = lvl[1]; v.dn = lvl[0];
    v.stop = s; v.act = a; v.rdy = y; v.bit_idx = bi;
    vecs.push_back(v);
  endtask

  // Expected lane activity for a burst of n bytes (byte k at bs[8k+:8]); n=0 drops request in LP-00.
  task automatic add_burst(input logic [23:0] bs, input int n);
    logic [7:0] cur, nxt;
    logic       more, last, any;
    any = (n > 0);
    last = 1'b0;
    add(1'b1, 8'hFF, 2'b11, 1'b1, 1'b0, 1'b0, -1);
    for (int i = 0; i < 2; i++) add(1'b1, 8'hFF, 2'b01, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 2; i++) add(any,  8'hFF, 2'b00, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 6; i++) add(any,  8'hFF, 2'b01, 1'b0, 1'b1, 1'b0, -1);
    cur = 8'hB8;
    for (int k = 0; k <= n; k++) begin
      more = (k < n);
      nxt  = more ? bs[8*k +: 8] : 8'hFF;
      for (int i = 0; i < 8; i++)
        add(more, (i == 7) ? nxt : 8'hFF, {cur[i], ~cur[i]}, 1'b0, 1'b1,
            (i == 7) ? more : 1'b0, i);
      last = cur[7];
      cur  = nxt;
    end
    for (int i = 0; i < 4; i++) add(1'b0, 8'hFF, {~last, last}, 1'b0, 1'b1, 1'b0, -1);
    for (int i = 0; i < 4; i++) add(1'b0, 8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, -1);
    add(1'b0, 8'hFF, 2'b11, 1'b1, 1'b0, 1'b0, -1);
  endtask

  initial begin
    shutdown = 1'b1;
    req      = 1'b0;
    data     = 8'h00;

    // Idle, single byte 5A, three bytes 11/22/33, request dropped in LP-00
    for (int i = 0; i < 8; i++) add(1'b0, 8'hFF, 2'b11, 1'b1, 1'b0, 1'b0, -1);
    add_burst(24'h00005A, 1);
    add_burst(24'h332211, 3);
    add_burst(24'h000000, 0);

    #2;
    chk("rst_dp", -1, dp, 1'b1);
    chk("rst_dn", -1, dn, 1'b1);
    chk("rst_stop", -1, stop, 1'b1);
    chk("rst_act", -1, act, 1'b0);
    chk("rst_rdy", -1, rdy, 1'b0);
    repeat (2) @(negedge clk);
    shutdown = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      req  = vecs[i].req;
      data = vecs[i].data;
      #1;
      chk("dp", i, dp, vecs[i].dp);
      chk("dn", i, dn, vecs[i].dn);
      chk("stopstate", i, stop, vecs[i].stop);
      chk("active_hs", i, act, vecs[i].act);
      chk("tx_ready", i, rdy, vecs[i].rdy);
      if (rdy === 1'b1) rdy_seen++;
`ifdef CSI_TX_BYTECLK_EN
      if (vecs[i].bit_idx >= 0) chk("byteclk", i, bclk, vecs[i].bit_idx < 4);
`endif
    end
    checks++;
    if (rdy_seen != 4) begin
      failures++;
      $display("FAIL ready_pulses got=%0d want=4", rdy_seen);
    end

    // Shutdown mid HS_DATA: 22 cycles after the request edge lands on data bit 3 of 8'hA5
    @(negedge clk);
    req  = 1'b1;
    data = 8'hA5;
    repeat (22) @(negedge clk);
    #1;
    chk("pre_sd_act", 0, act, 1'b1);
    chk("pre_sd_dp", 0, dp, 1'b0);
    chk("pre_sd_dn", 0, dn, 1'b1);
    shutdown = 1'b1;
    #1;
    chk("sd_dp", 1, dp, 1'b1);
    chk("sd_dn", 1, dn, 1'b1);
    chk("sd_stop", 1, stop, 1'b1);
    chk("sd_act", 1, act, 1'b0);
    chk("sd_rdy", 1, rdy, 1'b0);
    @(negedge clk);
    shutdown = 1'b0;
    req      = 1'b1;
    #1;
    chk("post_sd_stop", 2, stop, 1'b1);
    @(negedge clk);
    req = 1'b0;
    #1;
    chk("restart_dp", 3, dp, 1'b0);
    chk("restart_dn", 3, dn, 1'b1);
    chk("restart_stop", 3, stop, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
